// File: rtl/flexbex_ibex_pkg.sv
// Shared RV32I/RVC constants and field helpers for the instruction compressor and packer.
// Pure definitions: no logic, no latency, no flow control.
package flexbex_ibex_pkg;

  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_JAL   = 7'h6f;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [15:0] RVC_NOP = 16'h0001;

  typedef enum logic {
    PK_EMPTY = 1'b0,
    PK_PEND  = 1'b1
  } pack_state_e;

  // x8..x15 are the only registers reachable through the 3-bit RVC register fields
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  function automatic logic fits_simm6(input logic [11:0] imm);
    return imm[11:5] == {7{imm[5]}};
  endfunction

  function automatic logic is_word_off7(input logic [11:0] imm);
    return (imm[11:7] == 5'd0) && (imm[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/flexbex_ibex_compressor.sv
// Maps an eligible RV32I instruction to its RVC halfword; first matching rule wins.
// Purely combinational, zero latency, no flow control.
module flexbex_ibex_compressor
  import flexbex_ibex_pkg::*;
#(
  parameter bit COMPRESS_EN = 1'b1
) (
  input  logic [31:0] instr_i,
  output logic [15:0] instr_o,
  output logic        is_compressible_o
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [20:1] j_imm;
  logic        j_fits;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign i_imm  = instr_i[31:20];
  assign s_imm  = {instr_i[31:25], instr_i[11:7]};
  assign j_imm  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
  // C.J reaches +-2 KiB: the offset must sign-extend from bit 11
  assign j_fits = j_imm[20:11] == {10{j_imm[11]}};

  always_comb begin
    instr_o           = 16'h0000;
    is_compressible_o = 1'b0;
    if (opcode == OPC_OPIMM && funct3 == F3_ADD && rd != 5'd0 && fits_simm6(i_imm)) begin
      if (rs1 == rd && i_imm != 12'd0) begin
        instr_o           = {3'b000, i_imm[5], rd, i_imm[4:0], 2'b01};
        is_compressible_o = 1'b1;
      end else if (rs1 == 5'd0) begin
        instr_o           = {3'b010, i_imm[5], rd, i_imm[4:0], 2'b01};
        is_compressible_o = 1'b1;
      end
    end else if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == 7'd0 &&
                 rd != 5'd0 && rs2 != 5'd0) begin
      if (rs1 == 5'd0) begin
        instr_o           = {4'b1000, rd, rs2, 2'b10};
        is_compressible_o = 1'b1;
      end else if (rs1 == rd) begin
        instr_o           = {4'b1001, rd, rs2, 2'b10};
        is_compressible_o = 1'b1;
      end
    end else if (opcode == OPC_LOAD && funct3 == F3_WORD && is_creg(rd) && is_creg(rs1) &&
                 is_word_off7(i_imm)) begin
      instr_o           = {3'b010, i_imm[5:3], rs1[2:0], i_imm[2], i_imm[6], rd[2:0], 2'b00};
      is_compressible_o = 1'b1;
    end else if (opcode == OPC_STORE && funct3 == F3_WORD && is_creg(rs1) && is_creg(rs2) &&
                 is_word_off7(s_imm)) begin
      instr_o           = {3'b110, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6], rs2[2:0], 2'b00};
      is_compressible_o = 1'b1;
    end else if (opcode == OPC_JAL && rd == 5'd0 && j_fits) begin
      instr_o           = {3'b101, j_imm[11], j_imm[4], j_imm[9:8], j_imm[10], j_imm[6],
                           j_imm[7], j_imm[3:1], j_imm[5], 2'b01};
      is_compressible_o = 1'b1;
    end
    if (!COMPRESS_EN) begin
      instr_o           = 16'h0000;
      is_compressible_o = 1'b0;
    end
  end

endmodule

// File: rtl/flexbex_ibex_compressed_packer.sv
// Compresses an RV32I stream and packs halfwords into aligned words; output visible one cycle after accept.
// Single output register: in_ready_o = !out_valid_o | out_ready_i, word held stable while stalled.
module flexbex_ibex_compressed_packer
  import flexbex_ibex_pkg::*;
#(
  parameter bit          COMPRESS_EN = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_word_o,
  output logic [CNT_W-1:0] stat_cnt_o
);

  pack_state_e      state_q, state_d;
  logic [15:0]      pend_q, pend_d;
  logic             out_vld_q, out_vld_d;
  logic [31:0]      out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fdone_q, fdone_d;
  logic             fseen_q, fseen_d;

  logic [15:0] cmp_instr;
  logic        cmp_ok;
  logic        in_rdy;
  logic        acc;
  logic        flush_req;

  flexbex_ibex_compressor #(
    .COMPRESS_EN (COMPRESS_EN)
  ) u_compressor (
    .instr_i           (in_instr_i),
    .instr_o           (cmp_instr),
    .is_compressible_o (cmp_ok)
  );

  assign in_rdy = !out_vld_q || out_ready_i;
  assign acc    = in_valid_i && in_rdy;
  // Instructions win over flush; a served request stays latched until flush_i drops
  assign flush_req = flush_i && !in_valid_i && !fseen_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= PK_EMPTY;
      pend_q    <= 16'h0000;
      out_vld_q <= 1'b0;
      out_q     <= 32'h0000_0000;
      cnt_q     <= '0;
      fdone_q   <= 1'b0;
      fseen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      fdone_q   <= fdone_d;
      fseen_q   <= fseen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    out_vld_d = out_vld_q && !out_ready_i;
    out_d     = out_q;
    cnt_d     = cnt_q;
    fdone_d   = 1'b0;
    fseen_d   = fseen_q && flush_i;
    if (acc) begin
      if (state_q == PK_EMPTY) begin
        if (cmp_ok) begin
          pend_d  = cmp_instr;
          state_d = PK_PEND;
        end else begin
          out_d     = in_instr_i;
          out_vld_d = 1'b1;
        end
      end else begin
        out_vld_d = 1'b1;
        if (cmp_ok) begin
          out_d   = {cmp_instr, pend_q};
          pend_d  = 16'h0000;
          state_d = PK_EMPTY;
        end else begin
          // A 32-bit instruction straddles the word boundary; its upper half waits
          out_d  = {in_instr_i[15:0], pend_q};
          pend_d = in_instr_i[31:16];
        end
      end
      if (cmp_ok && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (flush_req) begin
      if (state_q == PK_EMPTY) begin
        fdone_d = 1'b1;
        fseen_d = 1'b1;
      end else if (in_rdy) begin
        out_d     = {RVC_NOP, pend_q};
        out_vld_d = 1'b1;
        pend_d    = 16'h0000;
        state_d   = PK_EMPTY;
        fdone_d   = 1'b1;
        fseen_d   = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready_o   = in_rdy;
    out_valid_o  = out_vld_q;
    out_word_o   = out_q;
    flush_done_o = fdone_q;
    stat_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_flexbex_ibex_compressed_packer.sv
// Directed and randomized checks of the compressing packer against a halfword-queue model.
module tb_flexbex_ibex_compressed_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic        flush_i;
  logic        flush_done_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_word_o;
  logic [15:0] stat_cnt_o;

  flexbex_ibex_compressed_packer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_instr_i   (in_instr_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_word_o   (out_word_o),
    .stat_cnt_o   (stat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  logic [15:0] hq[$];
  logic [31:0] exp_q[$];
  logic [15:0] m_cnt;
  bit          m_fd;
  bit          m_fseen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model for the next rising edge
  task automatic cycle(input bit v, input logic [31:0] w, input bit c_ok, input logic [15:0] c,
                       input bit fl, input bit ordy, output bit acc);
    bit m_rdy;
    in_valid_i  = v;
    in_instr_i  = w;
    flush_i     = fl;
    out_ready_i = ordy;
    #1;
    m_rdy = (exp_q.size() == 0) || ordy;
    check("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_word", out_word_o, exp_q[0]);
    check("in_ready", 32'(in_ready_o), 32'(m_rdy));
    check("flush_done", 32'(flush_done_o), 32'(m_fd));
    check("stat_cnt", 32'(stat_cnt_o), 32'(m_cnt));
    m_fd = 1'b0;
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    acc = v && m_rdy;
    if (acc) begin
      if (c_ok) begin
        hq.push_back(c);
        if (m_cnt != 16'hFFFF) m_cnt++;
      end else begin
        hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
      end
    end else if (!v && fl && !m_fseen) begin
      if (hq.size() == 0) begin
        m_fd = 1'b1;
        m_fseen = 1'b1;
      end else if (m_rdy) begin
        hq.push_back(16'h0001);
        m_fd = 1'b1;
        m_fseen = 1'b1;
      end
    end
    if (!fl) m_fseen = 1'b0;
    while (hq.size() >= 2) begin
      exp_q.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int ncyc);
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_instr_i  = 32'h0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (ncyc) @(negedge clk_i);
    rst_ni = 1'b1;
    hq.delete();
    exp_q.delete();
    m_cnt   = 16'h0;
    m_fd    = 1'b0;
    m_fseen = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input bit c_ok, input logic [15:0] c);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, w, c_ok, c, 1'b0, ($urandom % 4) != 0, acc);
      n++;
    end
    if (!acc) check("send_accept_timeout", 32'(in_ready_o), 32'h1);
  endtask

  task automatic do_flush();
    bit acc;
    int n;
    n = 0;
    m_fd = 1'b0;
    while (!m_fd && n < 50) begin
      cycle(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, ($urandom % 4) != 0, acc);
      n++;
    end
    if (!m_fd) check("flush_timeout", 32'(flush_done_o), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  // Builds a random instruction and, from its operands, the RVC form it must take (if any)
  task automatic gen(output logic [31:0] w, output bit ok, output logic [15:0] c);
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic [11:0] i12;
    logic [20:0] j;
    int          imm;
    int          kind;
    kind = int'($urandom % 6);
    rd   = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
    ok   = 1'b0;
    c    = 16'h0;
    case ($urandom % 3)
      0:       rs1 = rd;
      1:       rs1 = 5'd0;
      default: rs1 = 5'($urandom);
    endcase
    case (kind)
      0: begin
        imm = ($urandom % 4 == 0) ? int'($urandom_range(4095)) - 2048 : int'($urandom_range(80)) - 40;
        i12 = 12'(imm);
        w = {i12, rs1, 3'b000, rd, 7'h13};
        if (rd != 0 && rs1 == rd && imm >= -32 && imm <= 31 && imm != 0) begin
          ok = 1'b1;
          c = {3'b000, i12[5], rd, i12[4:0], 2'b01};
        end else if (rd != 0 && rs1 == 0 && imm >= -32 && imm <= 31) begin
          ok = 1'b1;
          c = {3'b010, i12[5], rd, i12[4:0], 2'b01};
        end
      end
      1: begin
        rs2 = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
        f7  = ($urandom % 5 == 0) ? 7'h20 : 7'h00;
        w = {f7, rs2, rs1, 3'b000, rd, 7'h33};
        if (f7 == 0 && rd != 0 && rs2 != 0 && rs1 == 0) begin
          ok = 1'b1;
          c = {4'b1000, rd, rs2, 2'b10};
        end else if (f7 == 0 && rd != 0 && rs2 != 0 && rs1 == rd) begin
          ok = 1'b1;
          c = {4'b1001, rd, rs2, 2'b10};
        end
      end
      2, 3: begin
        rd  = 5'($urandom_range(16, 6));
        rs1 = 5'($urandom_range(17, 6));
        rs2 = 5'($urandom_range(16, 7));
        imm = ($urandom % 3 == 0) ? int'($urandom_range(140)) - 8 : 4 * int'($urandom_range(35));
        i12 = 12'(imm);
        if (kind == 2) begin
          w = {i12, rs1, 3'b010, rd, 7'h03};
          if (rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 && imm >= 0 && imm <= 124 && imm % 4 == 0) begin
            ok = 1'b1;
            c = {3'b010, i12[5:3], rs1[2:0], i12[2], i12[6], rd[2:0], 2'b00};
          end
        end else begin
          w = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
          if (rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 && imm >= 0 && imm <= 124 && imm % 4 == 0) begin
            ok = 1'b1;
            c = {3'b110, i12[5:3], rs1[2:0], i12[2], i12[6], rs2[2:0], 2'b00};
          end
        end
      end
      4: begin
        rd  = ($urandom % 2 == 0) ? 5'd0 : 5'($urandom);
        imm = ($urandom % 4 == 0) ? 2 * (int'($urandom_range(1 << 19)) - (1 << 18))
                                  : 2 * (int'($urandom_range(2200)) - 1100);
        j = 21'(imm);
        w = {j[20], j[10:1], j[11], j[19:12], rd, 7'h6f};
        if (rd == 0 && imm >= -2048 && imm <= 2046) begin
          ok = 1'b1;
          c = {3'b101, j[11], j[4], j[9:8], j[10], j[6], j[7], j[3:1], j[5], 2'b01};
        end
      end
      default: w = {20'($urandom), rd, 7'h37};
    endcase
  endtask

  initial begin
    bit          acc;
    logic [31:0] w;
    bit          ok;
    logic [15:0] c;
    int          n;

    do_reset(2);
    check("rst_out_valid", 32'(out_valid_o), 32'h0);
    check("rst_out_word", out_word_o, 32'h0);
    check("rst_flush_done", 32'(flush_done_o), 32'h0);
    check("rst_stat_cnt", 32'(stat_cnt_o), 32'h0);

    cycle(1, 32'h00108093, 1, 16'h0085, 0, 1, acc);
    cycle(1, 32'hFFF10113, 1, 16'h117D, 0, 1, acc);
    check("pair_word", out_word_o, 32'h117D0085);
    check("pair_cnt", 32'(stat_cnt_o), 32'd2);

    cycle(1, 32'h000002B7, 0, 16'h0, 0, 1, acc);
    check("pass_word", out_word_o, 32'h000002B7);
    check("pass_cnt", 32'(stat_cnt_o), 32'd2);

    cycle(1, 32'h00108093, 1, 16'h0085, 0, 1, acc);
    cycle(1, 32'h123452B7, 0, 16'h0, 0, 1, acc);
    check("straddle_word", out_word_o, 32'h52B70085);
    cycle(0, 32'h0, 0, 16'h0, 1, 1, acc);
    check("flush_word", out_word_o, 32'h00011234);
    check("flush_pulse", 32'(flush_done_o), 32'h1);
    cycle(0, 32'h0, 0, 16'h0, 1, 1, acc);
    cycle(0, 32'h0, 0, 16'h0, 1, 1, acc);
    check("flush_once", 32'(flush_done_o), 32'h0);
    cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);

    cycle(1, 32'h0044A403, 1, 16'h40C0, 0, 1, acc);
    cycle(0, 32'h0, 0, 16'h0, 1, 1, acc);
    check("lw_flush_word", out_word_o, 32'h000140C0);
    cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);
    cycle(1, 32'h0804A403, 0, 16'h0, 0, 1, acc);
    check("lw_off128_word", out_word_o, 32'h0804A403);
    cycle(1, 32'h00008093, 0, 16'h0, 0, 1, acc);
    check("addi_imm0_word", out_word_o, 32'h00008093);
    cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);

    cycle(1, 32'h000002B7, 0, 16'h0, 0, 0, acc);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'hABCDE0B7, 0, 16'h0, 0, 0, acc);
      check("stall_in_ready", 32'(in_ready_o), 32'h0);
      check("stall_word", out_word_o, 32'h000002B7);
    end
    cycle(1, 32'hABCDE0B7, 0, 16'h0, 0, 1, acc);
    check("release_word", out_word_o, 32'hABCDE0B7);
    cycle(1, 32'h00100073, 0, 16'h0, 0, 1, acc);
    check("b2b_word1", out_word_o, 32'h00100073);
    cycle(1, 32'h0804A403, 0, 16'h0, 0, 1, acc);
    check("b2b_word2", out_word_o, 32'h0804A403);
    check("b2b_valid", 32'(out_valid_o), 32'h1);
    cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);

    cycle(1, 32'h00108093, 1, 16'h0085, 0, 1, acc);
    cycle(1, 32'h000002B7, 0, 16'h0, 0, 0, acc);
    check("prerst_valid", 32'(out_valid_o), 32'h1);
    do_reset(1);
    check("midrst_valid", 32'(out_valid_o), 32'h0);
    check("midrst_cnt", 32'(stat_cnt_o), 32'h0);
    cycle(0, 32'h0, 0, 16'h0, 1, 1, acc);
    check("postrst_flush_valid", 32'(out_valid_o), 32'h0);
    check("postrst_flush_pulse", 32'(flush_done_o), 32'h1);
    cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);

    for (int i = 0; i < 500; i++) begin
      n = int'($urandom % 16);
      if (n == 0) begin
        do_flush();
      end else if (n == 1) begin
        cycle(0, 32'h0, 0, 16'h0, 0, ($urandom % 2) != 0, acc);
      end else begin
        gen(w, ok, c);
        send(w, ok, c);
      end
    end

    do_flush();
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);
      n++;
    end
    cycle(0, 32'h0, 0, 16'h0, 0, 1, acc);
    check("drained_valid", 32'(out_valid_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
